// File: rtl/vlg_design_pkg.sv
// Shared types and constants for the BIST heartbeat block.
// Optional parity output is enabled with VLG_DESIGN_PARITY_EN.
package vlg_design_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

endpackage

// File: rtl/vlg_lfsr16.sv
// 16-bit Galois LFSR, shift right, with enable and zero-lockout reload.
// Reset is asynchronous and active-high on rst_n.
module vlg_lfsr16
    import vlg_design_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] q_step;

    assign q_step = (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);

    // An all-zero state would lock up forever, so recover regardless of en.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            q <= SEED;
        end else if (q == 16'h0000) begin
            q <= SEED;
        end else if (en) begin
            q <= q_step;
        end
    end

endmodule

// File: rtl/vlg_design_unit.sv
// BIST heartbeat: cycle counter, prescaled tick, LFSR and run/done sequencer.
// Define VLG_DESIGN_PARITY_EN to register ^lfsr_q onto the parity port.
module vlg_design_unit
    import vlg_design_pkg::*;
#(
    parameter int          CNT_W     = 8,
    parameter int          DIV       = 10,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF,
    parameter int          RUN_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic             tick,
    output logic [15:0]      lfsr_q,
    output logic             busy,
    output logic             done,
    output logic             parity
);

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [7:0]  RUN_LAST = 8'(RUN_TICKS - 1);

    logic [15:0] div_cnt;
    logic [7:0]  tick_cnt;
    state_t      state;
    state_t      state_nxt;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cyc_cnt <= '0;
            div_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            div_cnt <= tick ? 16'h0000 : div_cnt + 16'h0001;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == RUN && tick) begin
                tick_cnt <= tick_cnt + 8'h01;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = RUN;
            RUN: begin
                if (tick && tick_cnt == RUN_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    vlg_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (tick),
        .q    (lfsr_q)
    );

`ifdef VLG_DESIGN_PARITY_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            parity <= 1'b0;
        end else begin
            parity <= ^lfsr_q;
        end
    end
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_vlg_design_unit.sv
// Self-checking bench for vlg_design_unit: vector table, long run,
// mid-run reset and randomized reset pulses against a reference model.
module tb_vlg_design_unit;

    localparam int          CW   = 8;
    localparam int          DIV  = 10;
    localparam int          RT   = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] cyc_cnt;
    logic          tick;
    logic [15:0]   lfsr_q;
    logic          busy;
    logic          done;
    logic          parity;

    int n;
    int vectors;
    int miscompares;

    typedef struct {
        int          n;
        logic [7:0]  cyc;
        logic        tick;
        logic [15:0] lfsr;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tab[10];

    vlg_design_unit #(
        .CNT_W    (CW),
        .DIV      (DIV),
        .LFSR_SEED(SEED),
        .RUN_TICKS(RT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cyc_cnt(cyc_cnt),
        .tick   (tick),
        .lfsr_q (lfsr_q),
        .busy   (busy),
        .done   (done),
        .parity (parity)
    );

    always #5 clk = ~clk;

    // LFSR value after k edges since release: one Galois step per DIV edges.
    function automatic logic [15:0] lfsr_at(int k);
        logic [15:0] q;
        q = SEED;
        for (int i = 0; i < k / DIV; i++) begin
            q = {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
        end
        return q;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s n=%0d got %h expected %h", nm, n, act, exp);
        end
    endtask

    task automatic chk_model();
        logic exp_par;
        exp_par = 1'b0;
`ifdef VLG_DESIGN_PARITY_EN
        if (n >= 1) exp_par = ^lfsr_at(n - 1);
`endif
        chk("cyc_cnt", 32'(cyc_cnt), 32'(n % (1 << CW)));
        chk("tick", 32'(tick), 32'((n % DIV) == DIV - 1));
        chk("lfsr_q", 32'(lfsr_q), 32'(lfsr_at(n)));
        chk("busy", 32'(busy), 32'(n >= 1 && n < DIV * RT));
        chk("done", 32'(done), 32'(n >= DIV * RT));
        chk("parity", 32'(parity), 32'(exp_par));
    endtask

    // One clock: count edges out of reset, then settle at the negedge.
    task automatic step();
        @(posedge clk);
        if (rst_n) n = 0;
        else n++;
        @(negedge clk);
    endtask

    task automatic release_rst();
        rst_n = 1'b0;
        n = 0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        n = 0;
        tab[0] = '{0,  8'd0,  1'b0, 16'hACE1, 1'b0, 1'b0};
        tab[1] = '{1,  8'd1,  1'b0, 16'hACE1, 1'b1, 1'b0};
        tab[2] = '{9,  8'd9,  1'b1, 16'hACE1, 1'b1, 1'b0};
        tab[3] = '{10, 8'd10, 1'b0, 16'hE270, 1'b1, 1'b0};
        tab[4] = '{19, 8'd19, 1'b1, 16'hE270, 1'b1, 1'b0};
        tab[5] = '{20, 8'd20, 1'b0, 16'h7138, 1'b1, 1'b0};
        tab[6] = '{29, 8'd29, 1'b1, 16'h7138, 1'b1, 1'b0};
        tab[7] = '{30, 8'd30, 1'b0, 16'h389C, 1'b1, 1'b0};
        tab[8] = '{39, 8'd39, 1'b1, 16'h389C, 1'b1, 1'b0};
        tab[9] = '{40, 8'd40, 1'b0, 16'h1C4E, 1'b0, 1'b1};

        #1 rst_n = 1'b1;
        repeat (3) step();
        chk_model();
        release_rst();

        foreach (tab[i]) begin
            while (n < tab[i].n) step();
            chk("t_cyc", 32'(cyc_cnt), 32'(tab[i].cyc));
            chk("t_tick", 32'(tick), 32'(tab[i].tick));
            chk("t_lfsr", 32'(lfsr_q), 32'(tab[i].lfsr));
            chk("t_busy", 32'(busy), 32'(tab[i].busy));
            chk("t_done", 32'(done), 32'(tab[i].done));
        end

        // Long DONE dwell across several cycle-counter wraps.
        repeat (1100) begin
            step();
            chk_model();
            if (n == 256) chk("wrap", 32'(cyc_cnt), 32'h0);
        end
        chk("done_sticky", 32'(done), 32'h1);

        // Mid-run reset inside cycle 25, checked before any clock edge.
        rst_n = 1'b1;
        step();
        release_rst();
        while (n < 24) step();
        #2 rst_n = 1'b1;
        #1;
        chk("async_cyc", 32'(cyc_cnt), 32'h0);
        chk("async_tick", 32'(tick), 32'h0);
        chk("async_lfsr", 32'(lfsr_q), 32'(SEED));
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_par", 32'(parity), 32'h0);
        step();
        release_rst();
        repeat (45) begin
            step();
            chk_model();
        end

        // Random run lengths and random asynchronous reset pulses.
        repeat (20) begin
            repeat ($urandom_range(1, 120)) begin
                step();
                chk_model();
            end
            #($urandom_range(1, 3)) rst_n = 1'b1;
            n = 0;
            #1 chk_model();
            repeat ($urandom_range(1, 3)) step();
            release_rst();
            chk_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
